scan_chain_ctrl: RTL and testbench

Sequencer for a scan chain built from scan flip-flops with async set/reset (SE/SI muxed-D cells, non-inverting Q). The block loads a parallel test pattern serially into the chain, drops SE for a programmable number of functional capture clocks, then unloads the captured state serially into a parallel response register. It sits between a test/debug register interface and the chain's SE, SI and SO pins, and it shares CLK with the chain.

---
 rtl/scan_ctrl_pkg.sv | 17 +
 rtl/scan_shreg.sv | 26 ++
 rtl/scan_chain_ctrl.sv | 143 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding and default geometry for the scan chain sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } scan_state_t;

    localparam int CHAIN_LEN_DEF = 32;
    localparam int CAP_W_DEF     = 4;

endpackage

// File: rtl/scan_shreg.sv
// Width-N shift register with parallel load; shifts toward the MSB, new bit enters at bit 0.
// Latency: one cycle from load/shift to q.
// Backpressure: none; load wins over shift when both are asserted.
module scan_shreg #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] load_dat,
    input  logic         ser_in,
    output logic [N-1:0] q
);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q <= '0;
        end else if (load) begin
            q <= load_dat;
        end else if (shift) begin
            q <= {q[N-2:0], ser_in};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan sequencer: serial pattern load, programmable capture burst, serial unload into resp_o.
// Latency: done in cycle t+2*CHAIN_LEN+max(cap_n,1)+1 after start is sampled at edge t.
// Backpressure: start ignored unless IDLE; abort returns busy states to IDLE without done.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int CAP_W     = CAP_W_DEF,
    parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pat_i,
    input  logic [CAP_W-1:0]     cap_n,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [CAP_W-1:0]       cap_cnt;
    logic [CAP_W-1:0]       cap_n_q;
    logic [CAP_W-1:0]       cap_last;
    logic [CHAIN_LEN-1:0]   tx_q;
    logic [CHAIN_LEN-1:0]   rx_q;
    logic                   tx_load;
    logic [CHAIN_LEN-1:0]   tx_load_dat;
    logic                   unused_bits;

    // Abort reloads the serializer with zeros so SI is quiet back in IDLE.
    assign tx_load     = ((state == IDLE) && start) || (busy && abort);
    assign tx_load_dat = (state == IDLE) ? pat_i : '0;
    assign cap_last    = (cap_n_q == '0) ? '0 : cap_n_q - CAP_W'(1);
    assign SI          = tx_q[CHAIN_LEN-1];
    assign unused_bits = ^{tx_q[CHAIN_LEN-2:0], rx_q[CHAIN_LEN-1]};

    scan_shreg #(.N(CHAIN_LEN)) u_pat_ser (
        .CLK      (CLK),
        .RN       (RN),
        .load     (tx_load),
        .shift    (state == SHIFT),
        .load_dat (tx_load_dat),
        .ser_in   (1'b0),
        .q        (tx_q)
    );

    scan_shreg #(.N(CHAIN_LEN)) u_resp_des (
        .CLK      (CLK),
        .RN       (RN),
        .load     (1'b0),
        .shift    (state == UNLOAD),
        .load_dat ('0),
        .ser_in   (SO),
        .q        (rx_q)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            SE      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            cap_cnt <= '0;
            cap_n_q <= '0;
            resp_o  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        SE      <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        cap_n_q <= cap_n;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        SE    <= 1'b0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state   <= CAPTURE;
                        SE      <= 1'b0;
                        cnt     <= '0;
                        cap_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cap_cnt == cap_last) begin
                        state <= UNLOAD;
                        SE    <= 1'b1;
                    end else begin
                        cap_cnt <= cap_cnt + CAP_W'(1);
                    end
                end
                UNLOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        SE    <= 1'b0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        // Fold in the final SO bit so resp_o is already complete during DONE.
                        state  <= DONE;
                        SE     <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        resp_o <= {rx_q[CHAIN_LEN-2:0], SO};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    SE    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl on an 8-flop behavioural chain whose functional D inverts every position.
module tb_scan_chain_ctrl;

    localparam int L = 8;

    logic         CLK = 1'b0;
    logic         RN;
    logic         start;
    logic         abort;
    logic [L-1:0] pat_i;
    logic [3:0]   cap_n;
    logic         SE;
    logic         SI;
    logic         SO;
    logic         busy;
    logic         done;
    logic [L-1:0] resp_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    scan_chain_ctrl #(.CHAIN_LEN(L), .CAP_W(4), .CNT_W(3)) dut (
        .CLK    (CLK),
        .RN     (RN),
        .start  (start),
        .abort  (abort),
        .pat_i  (pat_i),
        .cap_n  (cap_n),
        .SE     (SE),
        .SI     (SI),
        .SO     (SO),
        .busy   (busy),
        .done   (done),
        .resp_o (resp_o)
    );

    // Position p is chain[p]; position 0 takes SI.
    logic [L-1:0] chain = '0;
    always @(posedge CLK) begin
        if (SE) chain <= {chain[L-2:0], SI};
        else    chain <= ~chain;
    end
    assign SO = chain[L-1];

    typedef struct {
        logic [7:0] pat;
        logic [3:0] cap;
        logic       ab;
        int         done_off;
        logic [7:0] resp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one full sequence from a negedge in IDLE; checks every cycle against the
    // spec-derived waveform and ends at a negedge back in IDLE.
    task automatic run_seq(input logic [7:0] pat, input logic [3:0] cap, input logic ab,
                           input int exp_done_off, input logic [7:0] exp_resp, input string nm);
        int c;
        int done_at;
        logic e_se;
        logic e_si;
        c = (cap == 0) ? 1 : int'(cap);
        done_at = -1;
        start = 1'b1; abort = ab; pat_i = pat; cap_n = cap;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; abort = 1'b0; pat_i = 8'($urandom); cap_n = 4'($urandom);
        for (int o = 1; o <= 2*L + c + 3; o++) begin
            e_se = ((o >= 1) && (o <= L)) || ((o >= L+c+1) && (o <= 2*L+c));
            e_si = (o <= L) ? pat[L-o] : 1'b0;
            chk($sformatf("%s SE o=%0d", nm, o), 32'(SE), 32'(e_se));
            chk($sformatf("%s SI o=%0d", nm, o), 32'(SI), 32'(e_si));
            chk($sformatf("%s busy o=%0d", nm, o), 32'(busy), 32'(o <= 2*L+c));
            if (done && done_at < 0) done_at = o;
            if (o == 2*L + c + 1)
                chk($sformatf("%s resp_o at done", nm), 32'(resp_o), 32'(exp_resp));
            @(negedge CLK);
        end
        chk($sformatf("%s done cycle", nm), done_at, exp_done_off);
        chk($sformatf("%s resp_o held", nm), 32'(resp_o), 32'(exp_resp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int d1;
        int d2;
        logic [7:0] p;
        logic [3:0] cp;

        tbl[0] = '{8'hA5, 4'd1,  1'b0, 18, 8'h5A};
        tbl[1] = '{8'hA5, 4'd0,  1'b0, 18, 8'h5A};
        tbl[2] = '{8'hA5, 4'd3,  1'b0, 20, 8'h5A};
        tbl[3] = '{8'h3C, 4'd2,  1'b0, 19, 8'h3C};
        tbl[4] = '{8'hFF, 4'd15, 1'b0, 32, 8'h00};
        tbl[5] = '{8'h00, 4'd4,  1'b0, 21, 8'h00};
        tbl[6] = '{8'hA5, 4'd1,  1'b1, 18, 8'h5A};

        RN = 1'b0; start = 1'b0; abort = 1'b0; pat_i = '0; cap_n = '0;
        repeat (3) @(negedge CLK);
        chk("reset SE", 32'(SE), 0);
        chk("reset SI", 32'(SI), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset resp_o", 32'(resp_o), 0);
        RN = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 7; i++)
            run_seq(tbl[i].pat, tbl[i].cap, tbl[i].ab, tbl[i].done_off, tbl[i].resp,
                    $sformatf("tbl%0d", i));

        // Abort in the 4th shift cycle; resp_o must keep the previous 5A.
        start = 1'b1; pat_i = 8'h3C; cap_n = 4'd1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort SE in shift4", 32'(SE), 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort SE next", 32'(SE), 0);
        chk("abort busy next", 32'(busy), 0);
        chk("abort SI next", 32'(SI), 0);
        d1 = 0;
        for (int o = 0; o < 2*L + 8; o++) begin
            if (done || busy) d1++;
            @(negedge CLK);
        end
        chk("abort no done/busy", d1, 0);
        chk("abort resp_o kept", 32'(resp_o), 32'h5A);

        // start held high: back-to-back runs with exactly one IDLE cycle between them.
        start = 1'b1; pat_i = 8'hA5; cap_n = 4'd1;
        @(posedge CLK);
        d1 = -1; d2 = -1;
        for (int o = 1; o <= 37; o++) begin
            @(negedge CLK);
            if (done) begin
                if (d1 < 0) d1 = o;
                else if (d2 < 0) d2 = o;
            end
            if (o == 19) begin
                chk("b2b idle SE", 32'(SE), 0);
                chk("b2b idle busy", 32'(busy), 0);
            end
            if (o == 20) chk("b2b restart SE", 32'(SE), 1);
        end
        chk("b2b first done", d1, 18);
        chk("b2b second done", d2, 37);
        chk("b2b resp_o", 32'(resp_o), 32'h5A);
        @(negedge CLK);
        start = 1'b0;
        chk("b2b idle after drop", 32'(busy), 0);
        @(negedge CLK);
        chk("b2b no restart", 32'(busy), 0);

        // Async reset mid-unload.
        start = 1'b1; pat_i = 8'hA5; cap_n = 4'd1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (L + 3) @(negedge CLK);
        chk("rn pre SE unload", 32'(SE), 1);
        RN = 1'b0;
        #1;
        chk("rn SE", 32'(SE), 0);
        chk("rn busy", 32'(busy), 0);
        chk("rn done", 32'(done), 0);
        chk("rn resp_o", 32'(resp_o), 0);
        chk("rn SI", 32'(SI), 0);
        @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        run_seq(8'h3C, 4'd2, 1'b0, 19, 8'h3C, "post_rn");

        // Random patterns against the capture-parity reference.
        for (int i = 0; i < 20; i++) begin
            p  = 8'($urandom);
            cp = 4'($urandom_range(0, 15));
            c  = (cp == 0) ? 1 : int'(cp);
            run_seq(p, cp, 1'($urandom_range(0, 1)), 2*L + c + 1,
                    (c % 2 == 1) ? ~p : p, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
